// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall bus, bubble/flush strobes, PC redirect,
// per-stage valid tracking, stall-cycle counter and stuck-pipeline watchdog.
module pipe_ctrl #(
    parameter int STAGES      = 5,
    parameter int FLUSH_STAGE = 4,
    parameter int WDOG_LIMIT  = 1024,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STAGES:0]   stall,
    output logic [STAGES-1:0] bubble,
    output logic [STAGES-1:0] flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    output logic [STAGES-1:0] stage_valid,
    output logic [PERF_W-1:0] stall_cycles,
    output logic              wdog_timeout
);

    localparam int CW = $clog2(WDOG_LIMIT + 1);
    localparam logic [CW-1:0] WLIM = CW'(WDOG_LIMIT);

    logic [STAGES:0]   hold;
    logic [STAGES:0]   upstream;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [PERF_W-1:0] cyc_q, cyc_d;
    logic [CW-1:0]     wdog_q, wdog_d;
    logic              tout_q, tout_d;

    // A request at stage k holds every younger stage and the PC as well.
    always_comb begin
        hold = '0;
        hold[STAGES] = stallreq[STAGES-1];
        for (int i = STAGES - 1; i >= 1; i--) begin
            hold[i] = hold[i+1] | stallreq[i-1];
        end
        hold[0] = hold[1];
        stall = flush_req ? '0 : hold;
    end

    // Bubble goes into the first stage past the held region; flush clears low stages.
    always_comb begin
        bubble = '0;
        flush  = '0;
        for (int i = 0; i < STAGES; i++) begin
            bubble[i] = stall[i] & ~stall[i+1];
            if (i < FLUSH_STAGE) begin
                flush[i] = flush_req;
            end
        end
        redirect_valid = flush_req;
        redirect_pc    = flush_req ? flush_pc : 32'd0;
    end

    // Next valid bits: flush clears, hold keeps, bubble zeroes, else shift in.
    always_comb begin
        valid_d  = '0;
        upstream = {valid_q, 1'b1};
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
                valid_d[i] = 1'b0;
            end else if (stall[i+1]) begin
                valid_d[i] = valid_q[i];
            end else if (stall[i]) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = upstream[i];
            end
        end
    end

    // Stall-cycle counter and saturating watchdog with sticky timeout.
    always_comb begin
        cyc_d  = stall[0] ? cyc_q + PERF_W'(1) : cyc_q;
        wdog_d = '0;
        if (stall[0] && !flush_req) begin
            wdog_d = (wdog_q == WLIM) ? wdog_q : wdog_q + CW'(1);
        end
        tout_d = tout_q | (wdog_d == WLIM);
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            cyc_q   <= '0;
            wdog_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            cyc_q   <= cyc_d;
            wdog_q  <= wdog_d;
            tout_q  <= tout_d;
        end
    end

    assign stage_valid  = valid_q;
    assign stall_cycles = cyc_q;
    assign wdog_timeout = tout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes expected responses from
// a stage-level reference model; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int S  = 5;
    localparam int FS = 4;
    localparam int WL = 6;
    localparam int PW = 8;

    logic          clk;
    logic          rst;
    logic [S-1:0]  stallreq;
    logic          flush_req;
    logic [31:0]   flush_pc;
    logic [S:0]    stall;
    logic [S-1:0]  bubble;
    logic [S-1:0]  flush;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [S-1:0]  stage_valid;
    logic [PW-1:0] stall_cycles;
    logic          wdog_timeout;

    pipe_ctrl #(
        .STAGES(S), .FLUSH_STAGE(FS), .WDOG_LIMIT(WL), .PERF_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .bubble(bubble), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stage_valid(stage_valid), .stall_cycles(stall_cycles),
        .wdog_timeout(wdog_timeout)
    );

    typedef struct packed {
        logic [S:0]    stall;
        logic [S-1:0]  bubble;
        logic [S-1:0]  flush;
        logic          rv;
        logic [31:0]   rpc;
        logic [S-1:0]  sv;
        logic [PW-1:0] sc;
        logic          wt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model state: stage valid flags, counters as plain integers
    int   mv[S+1];
    int   msc;
    int   mwd;
    bit   mto;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    task automatic step(input logic r, input logic [S-1:0] sr,
                        input logic fr, input logic [31:0] fpc);
        exp_t e;
        int   k;
        int   nv[S+1];
        @(posedge clk);
        #1;
        rst       = r;
        stallreq  = sr;
        flush_req = fr;
        flush_pc  = fpc;
        if (!r) begin
            for (int i = 1; i <= S; i++) mv[i] = 0;
            msc = 0;
            mwd = 0;
            mto = 0;
        end
        k = 0;
        if (!fr) begin
            for (int i = 1; i <= S; i++) if (sr[i-1]) k = i;
        end
        e.stall  = (k == 0) ? '0 : (S+1)'((1 << (k + 1)) - 1);
        e.bubble = (k > 0 && k < S) ? S'(1 << k) : '0;
        e.flush  = fr ? S'((1 << FS) - 1) : '0;
        e.rv     = fr;
        e.rpc    = fr ? fpc : 32'd0;
        for (int i = 1; i <= S; i++) e.sv[i-1] = (mv[i] != 0);
        e.sc     = PW'(msc);
        e.wt     = mto;
        q.push_back(e);
        if (!r) begin
            #1;
            chk("async_rst_valid", 64'(stage_valid), 64'd0);
            chk("async_rst_cycles", 64'(stall_cycles), 64'd0);
            chk("async_rst_wdog", 64'(wdog_timeout), 64'd0);
        end else begin
            nv[0] = 1;
            for (int i = 1; i <= S; i++) begin
                if (fr && i <= FS)          nv[i] = 0;
                else if (i <= k)            nv[i] = mv[i];
                else if (k > 0 && i == k+1) nv[i] = 0;
                else                        nv[i] = mv[i-1];
            end
            for (int i = 1; i <= S; i++) mv[i] = nv[i];
            if (k > 0) begin
                msc = (msc + 1) % (1 << PW);
                mwd = (mwd + 1 > WL) ? WL : mwd + 1;
            end else begin
                mwd = 0;
            end
            if (mwd == WL) mto = 1;
        end
    endtask

    // monitor: compare DUT outputs with the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", 64'(stall), 64'(e.stall));
            chk("bubble", 64'(bubble), 64'(e.bubble));
            chk("flush", 64'(flush), 64'(e.flush));
            chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
            chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
            chk("stage_valid", 64'(stage_valid), 64'(e.sv));
            chk("stall_cycles", 64'(stall_cycles), 64'(e.sc));
            chk("wdog_timeout", 64'(wdog_timeout), 64'(e.wt));
        end
    end

    initial begin
        logic [S-1:0] sr;
        rst       = 1'b0;
        stallreq  = '0;
        flush_req = 1'b0;
        flush_pc  = '0;
        mv[0]     = 1;
        for (int i = 1; i <= S; i++) mv[i] = 0;
        msc = 0;
        mwd = 0;
        mto = 0;

        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);
        for (int c = 0; c < 7; c++) step(1'b1, '0, 1'b0, '0);

        step(1'b1, 5'b00100, 1'b0, '0);
        for (int c = 0; c < 2; c++) step(1'b1, '0, 1'b0, '0);
        step(1'b1, 5'b10110, 1'b0, '0);
        step(1'b1, '0, 1'b0, '0);
        step(1'b1, 5'b00010, 1'b1, 32'hBFC0_0380);
        for (int c = 0; c < 6; c++) step(1'b1, '0, 1'b0, '0);

        for (int c = 0; c < 300; c++) step(1'b1, 5'b00001, 1'b0, '0);
        for (int c = 0; c < 3; c++) step(1'b1, '0, 1'b0, '0);

        for (int c = 0; c < 3; c++) step(1'b1, 5'b01000, 1'b0, '0);
        step(1'b0, 5'b01000, 1'b0, '0);
        for (int c = 0; c < 4; c++) step(1'b1, '0, 1'b0, '0);

        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < S; b++) sr[b] = ($urandom_range(0, 5) == 0);
            step(($urandom_range(0, 149) != 0), sr,
                 ($urandom_range(0, 11) == 0), $urandom);
        end

        for (int c = 0; c < 12; c++) step(1'b1, 5'b10000, 1'b0, '0);
        step(1'b1, '0, 1'b0, '0);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Parametrised pipeline controller; replaces the fixed, all-zero stall generator in the core.
- Turns per-stage stall requests and a flush request into a registered-aware stall bus, bubble and flush strobes, and a PC redirect.
- Tracks a valid bit per stage, counts stall cycles, and raises a watchdog flag on a stuck pipeline.
- Sits beside IF/ID/EX/MEM/WB in mycpu_core; stall bus bit 0 drives the PC register, bit i drives stage i's input register.

Parameters:
STAGES, 5, number of pipeline stages; stage 1 = IF, stage STAGES = WB
FLUSH_STAGE, 4, highest stage cleared by a flush (default 4 = MEM)
WDOG_LIMIT, 1024, consecutive stalled cycles before timeout asserts (must be ≥2)
PERF_W, 32, stall-cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
stallreq  in  STAGES  bit i-1 set: stage i cannot advance this cycle
flush_req  in  1  exception/eret redirect request, single-cycle pulse
flush_pc  in  32  redirect target, valid with flush_req
stall  out  STAGES+1  bit0 = PC hold, bit i = stage i input register hold
bubble  out  STAGES  bit i-1: load NOP/invalid into stage i register
flush  out  STAGES  bit i-1: clear stage i register
redirect_valid  out  1  PC must load redirect_pc
redirect_pc  out  32  redirect target
stage_valid  out  STAGES  registered valid bit per stage
stall_cycles  out  PERF_W  count of cycles with stall[0]=1
wdog_timeout  out  1  sticky stuck-pipeline flag

Behaviour:
- Reset (rst=0, async):
  - stage_valid=0, stall_cycles=0, wdog_timeout=0, internal watchdog count=0.
  - Combinational outputs follow their equations from these registered values.
- Stall source: k = highest index i with stallreq[i-1]=1.
  - stall[0..k]=1, stall[k+1..STAGES]=0.
  - No request: stall=0.
  - Younger stages are always held along with the requesting stage.
- Bubble: bubble[i-1] = stall[i-1] & ~stall[i], for i=1..STAGES.
  - At most one bubble bit is set.
  - No bubble when k=STAGES.
- Flush (flush_req=1) overrides stall:
  - stall=0, bubble=0, flush[0..FLUSH_STAGE-1]=1.
  - redirect_valid=1, redirect_pc=flush_pc.
  - Stages above FLUSH_STAGE advance normally.
- redirect_valid=0 and redirect_pc=0 when flush_req=0. All combinational outputs have zero latency.
- stage_valid update each rising edge:
  - flush[i-1]: valid[i] <= 0.
  - else stall[i]: hold.
  - else stall[i-1]: 0 (bubble).
  - else valid[i] <= valid[i-1], with valid[0] ≡ 1 after reset (fetch always issues).
  - Pipeline fills one stage per cycle after reset release; all STAGES bits are 1 after STAGES cycles with no stalls.
- stall_cycles: increments when stall[0]=1; wraps modulo 2^PERF_W; no increment on flush cycles.
- Watchdog:
  - Internal count increments while stall[0]=1 and flush_req=0; clears to 0 otherwise.
  - Saturates at WDOG_LIMIT.
  - wdog_timeout sets when the count reaches WDOG_LIMIT and stays set until reset.
- Simultaneous flush_req and stallreq: flush wins; stallreq is ignored that cycle.
- Reset asserted mid-stall: all registers clear immediately; outputs recompute combinationally.

Test Plan:
- Reset then no requests, STAGES=5 → stage_valid goes 00001, 00011 … 11111 over 5 cycles; stall=0; stall_cycles=0.
- stallreq=00100 (EX, load-use) for 1 cycle → stall=001111, bubble=01000, next cycle stage_valid[3] (MEM)=0, others hold/advance; stall_cycles=1.
- stallreq=00110 and 10000 applied together → k=5, stall=111111, bubble=0; stage_valid unchanged.
- flush_req=1, flush_pc=0xBFC00380, stallreq=00010 same cycle → stall=0, flush=01111, redirect_valid=1, redirect_pc=0xBFC00380; next cycle stage_valid=1xxxx with bits 1–4 = 0.
- WDOG_LIMIT=4, stallreq=00001 held 5 cycles → wdog_timeout rises at the 4th stalled cycle's edge and stays 1 after stallreq drops; stall_cycles=5.
- Drop rst low for one cycle mid-stall → stage_valid=0, stall_cycles=0, wdog_timeout=0 asynchronously, before the next clk edge.
